// File: rtl/imem_loader.sv
// imem_loader: turns a length-prefixed byte stream into sequential 32-bit instruction-memory writes,
// holding the CPU while an image is being loaded.
module imem_loader #(
    parameter int DEPTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             byte_valid,
    input  logic [7:0]       byte_data,
    output logic             byte_ready,
    output logic             mem_write,
    output logic [31:0]      mem_addr,
    output logic [31:0]      mem_data,
    output logic             cpu_hold,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [CNT_W-1:0] words_loaded
);
    typedef enum logic [2:0] {IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR} state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   n_q, n_d, cnt_q, cnt_d;
    logic [1:0]         lane_q, lane_d;
    logic [23:0]        buf_q, buf_d;
    logic [31:0]        addr_q, addr_d, data_q, data_d;
    logic               xfer, restart;
    logic [CNT_W-1:0]   hdr, cnt_inc;

    assign xfer    = byte_valid && byte_ready;
    assign restart = start && (state_q == IDLE || state_q == DONE || state_q == ERR);
    assign hdr     = CNT_W'({byte_data, n_q[7:0]});
    assign cnt_inc = cnt_q + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE, DONE, ERR: state_d = start ? HDR0 : state_q;
            HDR0:  state_d = xfer ? HDR1 : HDR0;
            HDR1:  state_d = !xfer ? HDR1 :
                             (hdr == '0) ? DONE :
                             (hdr > CNT_W'(DEPTH)) ? ERR : DATA;
            DATA:  state_d = (xfer && lane_q == 2'd3) ? WRITE : DATA;
            WRITE: state_d = (cnt_inc == n_q) ? DONE : DATA;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        byte_ready = 1'b0;
        mem_write  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        error      = 1'b0;
        cpu_hold   = 1'b0;
        case (state_q)
            HDR0, HDR1, DATA: begin
                byte_ready = 1'b1;
                busy       = 1'b1;
                cpu_hold   = 1'b1;
            end
            WRITE: begin
                mem_write = 1'b1;
                busy      = 1'b1;
                cpu_hold  = 1'b1;
            end
            DONE: done = 1'b1;
            ERR: begin
                error    = 1'b1;
                cpu_hold = 1'b1;
            end
            default: ;
        endcase
    end

    // Address/data are captured with the 4th byte so they stay stable after the write strobe.
    always_comb begin
        n_d    = n_q;
        cnt_d  = restart ? '0 : cnt_q;
        lane_d = restart ? 2'd0 : lane_q;
        buf_d  = buf_q;
        addr_d = addr_q;
        data_d = data_q;
        if (xfer && state_q == HDR0) n_d[7:0] = byte_data;
        if (xfer && state_q == HDR1) n_d = hdr;
        if (xfer && state_q == DATA) begin
            lane_d       = lane_q + 2'd1;
            buf_d[7:0]   = (lane_q == 2'd0) ? byte_data : buf_q[7:0];
            buf_d[15:8]  = (lane_q == 2'd1) ? byte_data : buf_q[15:8];
            buf_d[23:16] = (lane_q == 2'd2) ? byte_data : buf_q[23:16];
            addr_d       = (lane_q == 2'd3) ? 32'(cnt_q) : addr_q;
            data_d       = (lane_q == 2'd3) ? {byte_data, buf_q} : data_q;
        end
        if (state_q == WRITE) cnt_d = cnt_inc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            n_q    <= '0;
            cnt_q  <= '0;
            lane_q <= '0;
            buf_q  <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            n_q    <= n_d;
            cnt_q  <= cnt_d;
            lane_q <= lane_d;
            buf_q  <= buf_d;
            addr_q <= addr_d;
            data_q <= data_d;
        end
    end

    assign mem_addr     = addr_q;
    assign mem_data     = data_q;
    assign words_loaded = cnt_q;
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory write port: converts a byte stream (host/debug link) into 32-bit word writes on `write`/`addr_in`/`data` of the instruction memory.
- Frame format: 2-byte little-endian word count N, then 4·N payload bytes, each word little-endian.
- Holds the CPU via `cpu_hold` while loading, so fetch never observes a partially written image.

Parameters:
- DEPTH, 32, number of 32-bit words in the target instruction memory; maximum legal N.
- CNT_W, 16, width of the word-count header and of `words_loaded`.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start  input  1  one-cycle pulse; arms the loader for a new frame.
- byte_valid  input  1  source has a byte on `byte_data`.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle (transfer = byte_valid && byte_ready).
- mem_write  output  1  write strobe to instruction memory.
- mem_addr  output  32  word index (not byte address) of the write; bits above log2(DEPTH) are 0.
- mem_data  output  32  assembled instruction word.
- cpu_hold  output  1  core must stall/stay in reset while 1.
- busy  output  1  frame in progress.
- done  output  1  level; last frame completed successfully.
- error  output  1  level; last frame rejected (N > DEPTH).
- words_loaded  output  CNT_W  words written in current/last frame.

Behaviour:
- Reset (async, rst_n=0): state IDLE; every output 0, including `mem_addr`, `mem_data`, `words_loaded` and `cpu_hold`. A power-up image runs unheld.
- States: IDLE, HDR0, HDR1, DATA, WRITE, DONE, ERR.
- IDLE/DONE/ERR + start:
  - go to HDR0.
  - `busy`=1, `cpu_hold`=1; `done`, `error`, `words_loaded`, word index and byte lane cleared.
  - `start` is ignored in HDR0/HDR1/DATA/WRITE.
- `byte_ready` is 1 only in HDR0, HDR1 and DATA; it is a registered function of state and has no combinational path from `byte_valid`.
  - A byte presented in the same cycle as `start` is not accepted.
- HDR0: on transfer, latch N[7:0] and go to HDR1.
- HDR1: on transfer, latch N[15:8], then:
  - N==0 → DONE.
  - N>DEPTH → ERR.
  - otherwise → DATA.
- DATA:
  - On each transfer, write the byte into lane k of the word buffer (lane 0 = bits 7:0); k increments.
  - On the 4th byte (k wraps 3→0) → WRITE.
  - No transfer = no state change; stalls of any length are legal.
- WRITE (exactly 1 cycle):
  - `mem_write`=1, `mem_addr`=current index, `mem_data`=buffer.
  - Next edge: index+1, `words_loaded`+1.
  - Go to DONE if index+1==N, else DATA.
- Strobe qualification:
  - `mem_write` is 1 in no other state.
  - `mem_addr`/`mem_data` hold their last values otherwise and are registered outputs.
- Throughput: ≥5 cycles per word (4 byte cycles + 1 write cycle); latency from 4th byte accepted to `mem_write` high = 1 cycle.
- DONE: `done`=1, `busy`=0, `cpu_hold`=0.
- ERR: `error`=1, `busy`=0, `cpu_hold` stays 1 until the next `start` or reset. No memory writes occur.
- Address range: index never exceeds DEPTH−1 (guaranteed by the N check). Writes go to sequential indices from 0; no wrap.
- Reset mid-frame:
  - Immediate return to IDLE; the partial word is discarded.
  - Words already written stay in memory.
  - `cpu_hold` drops with reset.
- New `start` after DONE/ERR restarts at index 0 and overwrites memory from word 0.

Test Plan:
1. start; bytes 02 00, B7 07 00 00, 93 87 07 00, byte_valid always 1 → two `mem_write` pulses: addr 0 data 0x000007B7, addr 1 data 0x00078793; `done`=1, `words_loaded`=2, `cpu_hold` high from the cycle after start to DONE; 12 cycles start→done.
2. Same frame with byte_valid toggled 1/0 every cycle → identical writes and data, longer duration; no byte duplicated or dropped.
3. Header 21 00 (N=33 > DEPTH=32) → ERR: `error`=1, `cpu_hold`=1, `byte_ready`=0, zero `mem_write` pulses. A following start with a valid 1-word frame clears `error` and writes addr 0.
4. Header 00 00 → DONE two accepted bytes after start: no write, `words_loaded`=0, `done`=1.
5. N=3; assert rst_n=0 after 6 payload bytes → all outputs 0 immediately (async); exactly one write (addr 0) was issued. After release, a new frame reloads from addr 0.
6. Full N=32 frame of incrementing words → writes to addrs 0..31 in order, last addr 31, `words_loaded`=32. Start pulses injected mid-frame are ignored.
